dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/mem_pkg.sv | 13 +
 rtl/dmem_array.sv | 30 +++
 rtl/dmem_responder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage: synchronous byte-enabled write, registered read.
module dmem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 1024,
  parameter int IDX_W      = 10
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [IDX_W-1:0]        idx_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    re_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int BE_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // NOTE: storage and its read register have no reset; contents must survive rst_ni and a RAM macro has none.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_i[b]) mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_o <= mem[idx_i];
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed access latency and fault detection.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 1024,
  parameter int LATENCY    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic                    req_we_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_be_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BE_W-1:0]       be_q;
  logic                  rd_sel_q;
  logic                  err_q;

  logic                  accept;
  logic                  access;
  logic                  fault;
  logic                  mem_we;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);

  assign fault = (addr_q[1:0] != 2'b00) ||
                 ({2'b00, addr_q[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(MEM_WORDS));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          accept  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Faulting accesses never touch storage.
  assign mem_we = access && we_q && !fault;
  assign mem_re = access && !we_q && !fault;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
      rd_sel_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr_i;
        we_q    <= req_we_i;
        wdata_q <= req_wdata_i;
        be_q    <= req_be_i;
        cnt_q   <= CNT_W'(LATENCY - 1);
      end else if (state_q == ST_WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      // Response qualifiers only change at the access edge, so they hold through RESP and beyond.
      if (access) begin
        rd_sel_q <= !we_q && !fault;
        err_q    <= fault;
      end
    end
  end

  dmem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .be_i    (be_q),
    .idx_i   (addr_q[IDX_W+1:2]),
    .wdata_i (wdata_q),
    .re_i    (mem_re),
    .rdata_o (mem_rdata)
  );

  // Stores and faults return zero; the array's read register is only meaningful after a good load.
  assign rsp_rdata_o = rd_sel_q ? mem_rdata : '0;
  assign rsp_err_o   = err_q;

endmodule
